// File: rtl/universal_shift_register.sv
// Multi-mode shift register: DEPTH stages of WIDTH bits with hold, shift-up,
// shift-down and parallel load, plus a saturating count of valid stages.
module universal_shift_register #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk1,
  input  logic                   rst1,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       in1,
  input  logic [WIDTH-1:0]       in2,
  input  logic [DEPTH*WIDTH-1:0] pin,
  output logic [WIDTH-1:0]       out1,
  output logic [WIDTH-1:0]       out2,
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [CW-1:0]          cnt,
  output logic                   full
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  mode_e                   op;
  logic [DEPTH*WIDTH-1:0]  sreg;
  logic [DEPTH*WIDTH-1:0]  up_v;
  logic [DEPTH*WIDTH-1:0]  dn_v;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_next;
  logic                    full_q;

  assign op = mode_e'(mode);

  // Stages live in one packed vector; the shifted images are built per stage
  // with constant indices so the end stages take the serial inputs and the
  // DEPTH = 1 case collapses to a single stage fed by in1 or in2.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_up_end
      assign up_v[0 +: WIDTH] = in1;
    end else begin : g_up_mid
      assign up_v[k*WIDTH +: WIDTH] = sreg[(k-1)*WIDTH +: WIDTH];
    end
    if (k == DEPTH - 1) begin : g_dn_end
      assign dn_v[k*WIDTH +: WIDTH] = in2;
    end else begin : g_dn_mid
      assign dn_v[k*WIDTH +: WIDTH] = sreg[(k+1)*WIDTH +: WIDTH];
    end
  end

  // Next fill count: shifts advance and saturate, load jumps straight to DEPTH.
  always_comb begin
    cnt_next = cnt_q;
    case (op)
      MODE_UP, MODE_DOWN: cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      MODE_LOAD:          cnt_next = CNT_MAX;
      default:            cnt_next = cnt_q;
    endcase
  end

  // Stage storage, fill count and full flag, all updated on the same edge.
  always_ff @(posedge clk1) begin
    if (rst1) begin
      sreg   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      case (op)
        MODE_UP:   sreg <= up_v;
        MODE_DOWN: sreg <= dn_v;
        MODE_LOAD: sreg <= pin;
        default:   sreg <= sreg;
      endcase
      cnt_q  <= cnt_next;
      full_q <= (cnt_next == CNT_MAX);
    end
  end

  assign pout = sreg;
  assign out1 = sreg[(DEPTH-1)*WIDTH +: WIDTH];
  assign out2 = sreg[0 +: WIDTH];
  assign cnt  = cnt_q;
  assign full = full_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register: an 8x4 instance driven with
// directed sequences then random traffic, and a 4x1 instance driven randomly.
module tb_universal_shift_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH 8, DEPTH 4
  logic        rst_a;
  logic [1:0]  mode_a;
  logic [7:0]  in1_a, in2_a, out1_a, out2_a;
  logic [31:0] pin_a, pout_a;
  logic [2:0]  cnt_a;
  logic        full_a;

  // Instance B: WIDTH 4, DEPTH 1
  logic        rst_b;
  logic [1:0]  mode_b;
  logic [3:0]  in1_b, in2_b, out1_b, out2_b;
  logic [3:0]  pin_b, pout_b;
  logic [0:0]  cnt_b;
  logic        full_b;

  universal_shift_register #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk1(clk), .rst1(rst_a), .mode(mode_a), .in1(in1_a), .in2(in2_a),
    .pin(pin_a), .out1(out1_a), .out2(out2_a), .pout(pout_a),
    .cnt(cnt_a), .full(full_a)
  );

  universal_shift_register #(.WIDTH(4), .DEPTH(1)) u_b (
    .clk1(clk), .rst1(rst_b), .mode(mode_b), .in1(in1_b), .in2(in2_b),
    .pin(pin_b), .out1(out1_b), .out2(out2_b), .pout(pout_b),
    .cnt(cnt_b), .full(full_b)
  );

  typedef struct {
    logic [31:0] pout;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] cnt;
    logic [31:0] full;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Reference contents as one integer (stage 0 in the low bits) plus a count.
  logic [63:0] mv [2];
  int unsigned mc [2];

  int compared   = 0;
  int mismatched = 0;

  task automatic model(input int i, input logic r, input logic [1:0] m,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [31:0] p, output exp_t e);
    int unsigned w, d;
    logic [63:0] wm, am;
    w  = (i == 0) ? 8 : 4;
    d  = (i == 0) ? 4 : 1;
    wm = (64'd1 << w) - 64'd1;
    am = (64'd1 << (w * d)) - 64'd1;
    if (r) begin
      mv[i] = '0;
      mc[i] = 0;
    end else begin
      case (m)
        2'b01: begin
          mv[i] = ((mv[i] << w) | ({56'd0, a} & wm)) & am;
          mc[i] = (mc[i] < d) ? mc[i] + 1 : d;
        end
        2'b10: begin
          mv[i] = (mv[i] >> w) | (({56'd0, b} & wm) << (w * (d - 1)));
          mc[i] = (mc[i] < d) ? mc[i] + 1 : d;
        end
        2'b11: begin
          mv[i] = {32'd0, p} & am;
          mc[i] = d;
        end
        default: ;
      endcase
    end
    e.pout = mv[i][31:0];
    e.out1 = 32'((mv[i] >> (w * (d - 1))) & wm);
    e.out2 = 32'(mv[i] & wm);
    e.cnt  = mc[i];
    e.full = (mc[i] == d) ? 32'd1 : 32'd0;
  endtask

  task automatic drive_a(input logic r, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic [31:0] p);
    exp_t e;
    rst_a = r; mode_a = m; in1_a = a; in2_a = b; pin_a = p;
    model(0, r, m, a, b, p, e);
    sb_a.push_back(e);
  endtask

  task automatic drive_b(input logic r, input logic [1:0] m, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] p);
    exp_t e;
    rst_b = r; mode_b = m; in1_b = a; in2_b = b; pin_b = p;
    model(1, r, m, {4'd0, a}, {4'd0, b}, {28'd0, p}, e);
    sb_b.push_back(e);
  endtask

  int bcyc = 0;

  // One clock of stimulus: A gets the given operation, B follows its own script.
  task automatic cyc(input logic r, input logic [1:0] m, input logic [7:0] a,
                     input logic [7:0] b, input logic [31:0] p);
    @(negedge clk);
    drive_a(r, m, a, b, p);
    if (bcyc < 2)       drive_b(1'b1, 2'b00, 4'h0, 4'h0, 4'h0);
    else if (bcyc == 2) drive_b(1'b0, 2'b01, 4'h5, 4'h0, 4'h0);
    else if (bcyc == 3) drive_b(1'b0, 2'b10, 4'h0, 4'hA, 4'h0);
    else drive_b(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 4'($urandom));
    bcyc++;
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
    end
  endtask

  // Monitor: every edge the DUTs present a new state; compare it to the oldest
  // outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a.pout", pout_a, e.pout);
        chk("a.out1", {24'd0, out1_a}, e.out1);
        chk("a.out2", {24'd0, out2_a}, e.out2);
        chk("a.cnt",  {29'd0, cnt_a}, e.cnt);
        chk("a.full", {31'd0, full_a}, e.full);
      end
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b.pout", {28'd0, pout_b}, e.pout);
        chk("b.out1", {28'd0, out1_b}, e.out1);
        chk("b.out2", {28'd0, out2_b}, e.out2);
        chk("b.cnt",  {31'd0, cnt_b}, e.cnt);
        chk("b.full", {31'd0, full_b}, e.full);
      end
    end
  end

  initial begin
    int spins;
    // reset for two edges, then fill 1,0,1,1 and one extra shift
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 32'h0);
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h00, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h00, 8'h00, 32'h0);
    // single pulse through the chain
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 2'b01, 8'h00, 8'h00, 32'h0);
    // load then serialise downwards
    cyc(1'b0, 2'b11, 8'h00, 8'h00, 32'hDDCCBBAA);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'b10, 8'h00, 8'h00, 32'h0);
    // load, hold, reverse direction
    cyc(1'b0, 2'b11, 8'h00, 8'h00, 32'h00010100);
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'b00, 8'h77, 8'h88, 32'h12345678);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b0, 2'b10, 8'h00, 8'h00, 32'h0);
    // reset during partial fill overrides a load
    cyc(1'b1, 2'b00, 8'h00, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    cyc(1'b1, 2'b11, 8'h00, 8'h00, 32'hFFFFFFFF);
    cyc(1'b0, 2'b01, 8'h01, 8'h00, 32'h0);
    // random traffic
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
          8'($urandom), 8'($urandom), $urandom);
    // drain the scoreboards with a bounded wait
    spins = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && spins < 10) begin
      @(posedge clk);
      #2;
      spins++;
    end
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb_a.size() + sb_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
